// File: rtl/vc_demux3_queue_sd.sv
// rtl/vc_demux3_queue_sd.sv - 1-to-3 val/rdy demux with 2-entry domain-tagged FIFO per lane
module vc_demux3_queue_sd #(
    parameter int p_nbits = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         domain,
    input  logic               in_val,
    output logic               in_rdy,
    input  logic [1:0]         in_sel,
    input  logic [p_nbits-1:0] in_msg,
    output logic               out0_val,
    input  logic               out0_rdy,
    output logic [p_nbits-1:0] out0_msg,
    output logic [1:0]         out0_domain,
    output logic               out1_val,
    input  logic               out1_rdy,
    output logic [p_nbits-1:0] out1_msg,
    output logic [1:0]         out1_domain,
    output logic               out2_val,
    input  logic               out2_rdy,
    output logic [p_nbits-1:0] out2_msg,
    output logic [1:0]         out2_domain,
    output logic               sel_err
);

    logic [1:0]         count   [3];
    logic               enq_ptr [3];
    logic               deq_ptr [3];
    logic [p_nbits-1:0] msg_q   [3][2];
    logic [1:0]         dom_q   [3][2];

    logic [2:0]         lane_val;
    logic [2:0]         lane_rdy;
    logic [2:0]         enq;
    logic [2:0]         deq;
    logic [p_nbits-1:0] head_msg [3];
    logic [1:0]         head_dom [3];

    assign lane_rdy = {out2_rdy, out1_rdy, out0_rdy};

    // Ready depends only on the selected lane's count, never on the consumer side.
    always_comb begin
        in_rdy = 1'b1;
        case (in_sel)
            2'd0:    in_rdy = (count[0] != 2'd2);
            2'd1:    in_rdy = (count[1] != 2'd2);
            2'd2:    in_rdy = (count[2] != 2'd2);
            default: in_rdy = 1'b1;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            lane_val[i] = (count[i] != 2'd0);
            enq[i]      = in_val && in_rdy && (in_sel == i[1:0]);
            deq[i]      = lane_val[i] && lane_rdy[i];
            // Empty lanes drive zeros so no stale payload or label escapes.
            head_msg[i] = lane_val[i] ? msg_q[i][deq_ptr[i]] : '0;
            head_dom[i] = lane_val[i] ? dom_q[i][deq_ptr[i]] : 2'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                count[i]   <= 2'd0;
                enq_ptr[i] <= 1'b0;
                deq_ptr[i] <= 1'b0;
            end
            sel_err <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (enq[i])
                    enq_ptr[i] <= ~enq_ptr[i];
                if (deq[i])
                    deq_ptr[i] <= ~deq_ptr[i];
                case ({enq[i], deq[i]})
                    2'b10:   count[i] <= count[i] + 2'd1;
                    2'b01:   count[i] <= count[i] - 2'd1;
                    default: count[i] <= count[i];
                endcase
            end
            sel_err <= in_val && (in_sel == 2'd3);
        end
    end

    // Payload storage needs no reset: it is only observable through a nonzero count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (enq[i]) begin
                msg_q[i][enq_ptr[i]] <= in_msg;
                dom_q[i][enq_ptr[i]] <= domain;
            end
        end
    end

    assign out0_val    = lane_val[0];
    assign out0_msg    = head_msg[0];
    assign out0_domain = head_dom[0];
    assign out1_val    = lane_val[1];
    assign out1_msg    = head_msg[1];
    assign out1_domain = head_dom[1];
    assign out2_val    = lane_val[2];
    assign out2_msg    = head_msg[2];
    assign out2_domain = head_dom[2];

endmodule

// File: tb/tb_vc_demux3_queue_sd.sv
// tb/tb_vc_demux3_queue_sd.sv - scoreboard bench for vc_demux3_queue_sd
module tb_vc_demux3_queue_sd;

    logic       clk;
    logic       reset;
    logic [1:0] domain;
    logic       in_val;
    logic       in_rdy;
    logic [1:0] in_sel;
    logic [7:0] in_msg;
    logic       out0_val, out1_val, out2_val;
    logic       out0_rdy, out1_rdy, out2_rdy;
    logic [7:0] out0_msg, out1_msg, out2_msg;
    logic [1:0] out0_domain, out1_domain, out2_domain;
    logic       sel_err;

    vc_demux3_queue_sd #(.p_nbits(8)) dut (
        .clk(clk), .reset(reset), .domain(domain),
        .in_val(in_val), .in_rdy(in_rdy), .in_sel(in_sel), .in_msg(in_msg),
        .out0_val(out0_val), .out0_rdy(out0_rdy), .out0_msg(out0_msg), .out0_domain(out0_domain),
        .out1_val(out1_val), .out1_rdy(out1_rdy), .out1_msg(out1_msg), .out1_domain(out1_domain),
        .out2_val(out2_val), .out2_rdy(out2_rdy), .out2_msg(out2_msg), .out2_domain(out2_domain),
        .sel_err(sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       oval [3];
    logic       ordy [3];
    logic [7:0] omsg [3];
    logic [1:0] odom [3];
    assign oval[0] = out0_val; assign oval[1] = out1_val; assign oval[2] = out2_val;
    assign ordy[0] = out0_rdy; assign ordy[1] = out1_rdy; assign ordy[2] = out2_rdy;
    assign omsg[0] = out0_msg; assign omsg[1] = out1_msg; assign omsg[2] = out2_msg;
    assign odom[0] = out0_domain; assign odom[1] = out1_domain; assign odom[2] = out2_domain;

    logic [9:0] sbq [3][$];
    logic       exp_err;
    int         errors;
    int         checks;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check all outputs against the scoreboard, update it, then advance one edge.
    task automatic cycle();
        logic rdy_exp;
        logic [9:0] e;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("out%0d_val", i), 32'(oval[i]), 32'(sbq[i].size() != 0));
            if (sbq[i].size() != 0) begin
                e = sbq[i][0];
                chk($sformatf("out%0d_msg", i), 32'(omsg[i]), 32'(e[7:0]));
                chk($sformatf("out%0d_domain", i), 32'(odom[i]), 32'(e[9:8]));
            end else begin
                chk($sformatf("out%0d_msg_empty", i), 32'(omsg[i]), 32'd0);
                chk($sformatf("out%0d_domain_empty", i), 32'(odom[i]), 32'd0);
            end
        end
        chk("sel_err", 32'(sel_err), 32'(exp_err));
        rdy_exp = (in_sel == 2'd3) ? 1'b1 : (sbq[in_sel].size() != 2);
        chk("in_rdy", 32'(in_rdy), 32'(rdy_exp));
        for (int i = 0; i < 3; i++)
            if (sbq[i].size() != 0 && ordy[i])
                void'(sbq[i].pop_front());
        if (in_val && rdy_exp && in_sel != 2'd3)
            sbq[in_sel].push_back({domain, in_msg});
        exp_err = in_val && (in_sel == 2'd3);
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] m, input logic [1:0] d);
        in_val = v;
        in_sel = s;
        in_msg = m;
        domain = d;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        exp_err = 1'b0;
        reset = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 2'd0);
        out0_rdy = 1'b0; out1_rdy = 1'b0; out2_rdy = 1'b0;
        #1;
        chk("reset_in_rdy", 32'(in_rdy), 32'd1);
        chk("reset_sel_err", 32'(sel_err), 32'd0);
        chk("reset_vals", 32'({out2_val, out1_val, out0_val}), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;

        // Single message to lane 1
        drive(1'b1, 2'd1, 8'hA5, 2'd1);
        cycle();
        drive(1'b0, 2'd1, 8'h00, 2'd0);
        #1;
        chk("t1_out1_msg", 32'(out1_msg), 32'hA5);
        chk("t1_out1_domain", 32'(out1_domain), 32'd1);
        chk("t1_out0_out2_val", 32'({out2_val, out0_val}), 32'd0);
        cycle();
        out1_rdy = 1'b1;
        cycle();
        out1_rdy = 1'b0;

        // Fill lane 2, check backpressure is per lane, then drain in order
        drive(1'b1, 2'd2, 8'h11, 2'd0);
        cycle();
        drive(1'b1, 2'd2, 8'h22, 2'd3);
        cycle();
        drive(1'b1, 2'd2, 8'h33, 2'd0);
        cycle();
        drive(1'b0, 2'd0, 8'h00, 2'd0);
        cycle();
        drive(1'b0, 2'd2, 8'h00, 2'd0);
        out2_rdy = 1'b1;
        cycle();
        cycle();
        cycle();
        out2_rdy = 1'b0;

        // Streaming through lane 0 across pointer wrap
        out0_rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 2'd0, 8'h30 + 8'(k), 2'(k % 3));
            cycle();
        end
        drive(1'b0, 2'd0, 8'h00, 2'd0);
        cycle();
        out0_rdy = 1'b0;

        // Mixed domains into lane 0
        drive(1'b1, 2'd0, 8'h03, 2'd0);
        cycle();
        drive(1'b1, 2'd0, 8'h04, 2'd2);
        cycle();
        drive(1'b0, 2'd0, 8'h00, 2'd0);
        out0_rdy = 1'b1;
        cycle();
        cycle();
        cycle();
        out0_rdy = 1'b0;

        // Invalid selector: single pulse, then back-to-back pulses
        drive(1'b1, 2'd3, 8'h77, 2'd1);
        cycle();
        drive(1'b0, 2'd0, 8'h00, 2'd0);
        cycle();
        cycle();
        drive(1'b1, 2'd3, 8'h78, 2'd1);
        cycle();
        cycle();
        drive(1'b0, 2'd0, 8'h00, 2'd0);
        cycle();
        cycle();

        // Asynchronous reset with buffered data
        drive(1'b1, 2'd0, 8'hC1, 2'd1);
        cycle();
        drive(1'b1, 2'd0, 8'hC2, 2'd2);
        cycle();
        drive(1'b1, 2'd1, 8'hD1, 2'd3);
        cycle();
        drive(1'b0, 2'd0, 8'h00, 2'd0);
        #1;
        chk("pre_reset_vals", 32'({out2_val, out1_val, out0_val}), 32'b011);
        #1;
        reset = 1'b0;
        #1;
        chk("async_vals", 32'({out2_val, out1_val, out0_val}), 32'd0);
        chk("async_msgs", {8'h00, out2_msg, out1_msg, out0_msg}, 32'd0);
        chk("async_in_rdy", 32'(in_rdy), 32'd1);
        for (int i = 0; i < 3; i++)
            sbq[i].delete();
        exp_err = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        out0_rdy = 1'b1; out1_rdy = 1'b1; out2_rdy = 1'b1;
        cycle();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 2'(k), 8'hE0 + 8'(k), 2'(k));
            cycle();
        end
        drive(1'b0, 2'd0, 8'h00, 2'd0);
        cycle();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vc_demux3_queue_sd.md
# vc_demux3_queue_sd

Three-output demultiplexer with per-lane buffering, the steering counterpart to the same-domain 3-input mux. It accepts one message per cycle on a val/rdy input and routes it by `in_sel` into one of three 2-entry FIFO lanes. Each lane presents its own val/rdy output. Every message carries the security domain it was accepted under, so downstream logic keeps `{Domain domain}` labelling intact across the buffer.

## Interface
- `p_nbits`, default 1: message width in bits.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low. Low clears all state immediately, independent of `clk`.
- `domain`  in  2  label `{L}`. Domain of the current input message; captured with each accepted message.
- `in_val`  in  1  label `{Domain domain}`. Input message valid.
- `in_rdy`  out  1  label `{Domain domain}`. Input ready.
- `in_sel`  in  2  label `{Domain domain}`. Destination lane: 0, 1 or 2. Value 3 is invalid.
- `in_msg`  in  p_nbits  label `{Domain domain}`. Input payload.
- `outN_val`, N = 0..2  out  1  lane N holds at least one entry.
- `outN_rdy`, N = 0..2  in  1  consumer of lane N is ready.
- `outN_msg`, N = 0..2  out  p_nbits  head payload of lane N. Label `{Domain outN_domain}`.
- `outN_domain`, N = 0..2  out  2  domain captured with the head entry of lane N.
- `sel_err`  out  1  registered one-cycle pulse: an `in_sel`=3 message was accepted and dropped.

## Operation
- Each lane is a 2-entry circular FIFO. Per-lane state:
  - 1-bit enqueue pointer and 1-bit dequeue pointer, each wrapping 1→0.
  - 2-bit count, range 0..2.
  - Storage of {p_nbits payload, 2-bit domain} per entry.
- `in_rdy` is combinational:
  - `in_sel` 0..2: `in_rdy` = (count of the selected lane != 2).
  - `in_sel` 3: `in_rdy` = 1.
- Enqueue fires when `in_val && in_rdy`. It writes {`in_msg`, `domain`} at the selected lane's enqueue pointer.
- Dequeue of lane N fires when `outN_val && outN_rdy`.
- Count update per lane:
  - +1 on enqueue only.
  - −1 on dequeue only.
  - Unchanged when both fire.
- No bypass path. A full lane reports `in_rdy`=0 even if it dequeues in the same cycle. An empty lane never presents same-cycle input data.
- `outN_val` = (count != 0). `outN_msg` and `outN_domain` come from the entry at the dequeue pointer.
- While lane N is empty, `outN_msg` and `outN_domain` are driven to 0, so no stale data or label leaks out.
- `in_sel`=3 handshake: the message is consumed, no lane changes, and `sel_err` is 1 in the following cycle only. Each further accepted `in_sel`=3 produces its own pulse.
- Lanes are independent. One lane being full never blocks transfers to another lane.
- Reset asserted, including mid-transfer:
  - All counts and pointers go to 0.
  - All `outN_val`, `outN_msg`, `outN_domain` and `sel_err` go to 0.
  - Buffered contents are discarded and never re-emitted.
- Reset outputs: `outN_val`=0, `outN_msg`=0, `outN_domain`=0, `sel_err`=0. `in_rdy` evaluates to 1, since all lanes are empty.

## Timing
- Latency is 1 cycle. A message accepted at edge k is visible on `outN_*` with `outN_val`=1 after edge k.
- Peak throughput per lane is 1 message/cycle with continuous enqueue and dequeue at count 1.
- A full lane regains `in_rdy` in the cycle after its first dequeue edge.
- `sel_err` rises after the accepting edge and falls after the next edge.
- Deassertion of `reset` takes effect at the next rising edge. No enqueue or dequeue occurs while `reset` is low.
- Combinational paths:
  - `in_sel` → `in_rdy`.
  - State → `outN_*`.
  - There is no path from `outN_rdy` to `in_rdy`.

## Test plan
- Reset, then one message: `in_msg`=8'hA5, `in_sel`=1, `domain`=1 → `out1_val`=1, `out1_msg`=A5, `out1_domain`=1 one cycle later. `out0_val` and `out2_val` stay 0.
- Fill lane 2 with 11, 22 while `out2_rdy`=0 → `in_rdy`=0 for `in_sel`=2 and `in_rdy`=1 for `in_sel`=0. Then raise `out2_rdy` → outputs 11 then 22 in order, and `in_rdy` for `in_sel`=2 returns after the first dequeue.
- Stream 6 messages to lane 0 with `out0_rdy`=1 continuously → 1 message/cycle, order preserved through pointer wrap, count never exceeds 1.
- Mixed domains into lane 0: (msg 3, domain 0) then (msg 4, domain 2) → `out0_domain` reads 0, then 2 in step with the payload. `out0_msg`=0 once the lane is empty.
- `in_sel`=3, `in_val`=1 → `in_rdy`=1, `sel_err` high exactly one cycle, all lane counts unchanged.
- Load lane 0 with 2 entries and lane 1 with 1 entry, then pulse `reset` low between clock edges → all `outN_val`=0 and `outN_msg`=0 immediately. After release, nothing is re-emitted and lanes 0..2 all accept new input.
